// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer: FSM state encoding,
// standard round counts and the round-key index width.
package aes_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam int AES192_ROUNDS = 12;
  localparam int AES256_ROUNDS = 14;
  localparam int RK_IDX_W      = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the crypto wrapper / round
// datapath (master side) and the round sequencer (slave side).
interface aes_round_ctrl_if;
  import aes_pkg::*;

  // Both handshakes transfer on a cycle where valid and ready are high together;
  // valid, once raised, is held by its source until that cycle, and ready may be
  // raised or dropped freely without waiting for valid.
  logic                in_valid;
  logic                in_ready;
  logic                dp_load;
  logic                dp_round_en;
  logic                mc_enable;
  logic [RK_IDX_W-1:0] rk_idx;
  logic                busy;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  in_valid, out_ready,
    output in_ready, dp_load, dp_round_en, mc_enable, rk_idx, busy, out_valid
  );

  modport master (
    output in_valid, out_ready,
    input  in_ready, dp_load, dp_round_en, mc_enable, rk_idx, busy, out_valid
  );

endinterface

// File: rtl/aes_round_timer.sv
// Per-round cycle counter for a multicycle round datapath; last_o marks the
// cycle on which the round result is captured.
module aes_round_timer #(
  parameter int ROUND_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clear_i,
  output logic last_o
);

  localparam int            CW   = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROUND_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer: LOAD, NUM_ROUNDS-1 full rounds, FINAL.
// Optional build macro AES_RC_ABORT_EN adds an abort input that drops an in-flight block.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS   = AES128_ROUNDS,
  parameter int ROUND_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef AES_RC_ABORT_EN
  input  logic            abort,
`endif
  aes_round_ctrl_if.slave bus,
  output aes_state_e      dbg_state_o
);

  if (NUM_ROUNDS != AES128_ROUNDS && NUM_ROUNDS != AES192_ROUNDS &&
      NUM_ROUNDS != AES256_ROUNDS) begin : g_bad_num_rounds
    $error("aes_round_ctrl: NUM_ROUNDS must be 10, 12 or 14");
  end
  if (ROUND_CYCLES < 1 || ROUND_CYCLES > 8) begin : g_bad_round_cycles
    $error("aes_round_ctrl: ROUND_CYCLES must be in 1..8");
  end

  localparam logic [RK_IDX_W-1:0] LAST_FULL = RK_IDX_W'(NUM_ROUNDS - 1);
  localparam logic [RK_IDX_W-1:0] RK_LAST   = RK_IDX_W'(NUM_ROUNDS);

  aes_state_e          state_q, state_d;
  logic [RK_IDX_W-1:0] round_q, round_d;
  logic                running;
  logic                last_cycle;
  logic                abort_now;

  assign running = (state_q == ROUND) || (state_q == FINAL);

`ifdef AES_RC_ABORT_EN
  assign abort_now = abort & ((state_q == LOAD) || running);
`else
  assign abort_now = 1'b0;
`endif

  aes_round_timer #(
    .ROUND_CYCLES(ROUND_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (running),
    .clear_i(~running | abort_now),
    .last_o (last_cycle)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = LOAD;
          round_d = RK_IDX_W'(1);
        end
      end
      LOAD: begin
        state_d = (NUM_ROUNDS == 1) ? FINAL : ROUND;
      end
      ROUND: begin
        // round_q names the round that is completing on this capture cycle
        if (last_cycle) begin
          round_d = round_q + RK_IDX_W'(1);
          if (round_q == LAST_FULL) begin
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        if (last_cycle) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
    if (abort_now) begin
      state_d = IDLE;
      round_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.dp_load     = (state_q == LOAD);
  assign bus.dp_round_en = running & last_cycle & ~abort_now;
  assign bus.mc_enable   = (state_q == ROUND);
  assign bus.busy        = (state_q != IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.rk_idx      = (state_q == ROUND) ? round_q :
                           ((state_q == FINAL) || (state_q == DONE)) ? RK_LAST : '0;
  assign dbg_state_o     = state_q;

endmodule
